fir_sequencer: RTL
==================

// Module: fir_sequencer
// PURPOSE
//  Time-multiplexed controller for the 31-tap symmetric FIR between the SPI slave and the output.
//  - Takes one 10-bit ADC sample per sample_valid pulse and stores it in a 31-entry ring.
//  - Sequences one multiplier over 16 symmetric tap pairs, reading coefficients from an external ROM.
//  - Rounds and saturates the sum, then presents one filtered sample with a one-cycle out_valid strobe.
// PARAMETERS
//  DATA_W  10  sample width (unsigned ADC code); also the filtered output width
//  COEF_W  16  coefficient width, signed Q1.15
//  NTAPS   31  filter length; must be odd; NHALF = (NTAPS+1)/2 = 16 coefficient addresses
//  ACC_W   32  signed accumulator width
//  FRAC    15  fractional bits removed at rounding
// PORTS
//  clk          in   1       system clock
//  reset        in   1       asynchronous, active-low reset
//  sample_valid in   1       1-cycle pulse: sample_in valid (already synchronised to clk)
//  sample_in    in   DATA_W  new unsigned sample x[n]
//  coef_addr    out  4       coefficient ROM address 0..NHALF-1
//  coef_data    in   COEF_W  signed coefficient; registered ROM, valid 1 cycle after coef_addr
//  busy         out  1       high whenever state != IDLE
//  out_valid    out  1       1-cycle pulse: filtered is valid
//  filtered     out  DATA_W  y[n]; holds its value until the next out_valid
//  overrun      out  1       sticky: a sample was dropped because the block was busy
//  clr_overrun  in   1       synchronous clear of overrun; loses to a same-cycle set
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE; wr_ptr=0; all ring entries=0; acc=0.
//   All outputs 0: filtered, out_valid, busy, overrun, coef_addr.
//   Reset mid-computation aborts it: no out_valid is produced.
//  States: IDLE -> LOAD -> MAC(k=0..15) -> ROUND -> IDLE.
//  IDLE: sample_valid=1 is accepted at edge E0.
//   - ring[wr_ptr] <= sample_in; base <= wr_ptr; wr_ptr <= wr_ptr+1, wrapping 30->0.
//   - Go to LOAD.
//  LOAD (1 cycle): acc <= 0; coef_addr=0.
//  MAC k (16 cycles): coef_addr = k+1, held at 15 when k=15; coef_data = c[k].
//   - For k<15: pair = x[n-k] + x[n-30+k], 11-bit unsigned.
//   - For k=15: pair = x[n-15], centre tap, not doubled.
//   - Index arithmetic: x[n-j] = ring[(base-j) mod 31].
//   - acc <= acc + signed(c[k]) * signed({1'b0,pair}); the product fits in 28 bits.
//  ROUND (1 cycle): r = (acc + 2^(FRAC-1)) >>> FRAC, i.e. round half up.
//   - Saturate: r<0 -> 0; r>1023 -> 1023.
//   - filtered <= result and out_valid <= 1 at edge E19, so out_valid is high in the cycle after E19.
//   - Next state is IDLE.
//  Latency and throughput: out_valid is exactly 19 clk after the accepting edge; max 1 sample per 19 clk.
//  sample_valid when busy=1 (including the ROUND cycle):
//   - The sample is dropped and overrun is set.
//   - The ring, wr_ptr and the computation in flight are unaffected.
//  Start-up: ring entries not yet written read as 0 (reset contents), so the first 30 outputs use zero history.
//  Wrap-around: the pointer modulo 31 is handled by a compare-and-wrap, not a power-of-2 mask.
// STRUCTURE
//  fir_pkg holds:
//   - typedef enum {IDLE, LOAD, MAC, ROUND} fir_state_t
//   - localparams NTAPS, NHALF, DATA_W, COEF_W, ACC_W, FRAC
//   - function wrap31(ptr, off) for modular indexing
//  Sub-module fir_sample_ring:
//   - 31 x DATA_W registers with async active-low clear and one write port.
//   - Two combinational read ports, (base-k) and (base-30+k) mod 31.
//  fir_sequencer contains the FSM, tap counter, adder, multiplier, accumulator, and round/saturate stage.
// TESTING
//  All scenarios use a bench-model ROM with 1-cycle registered read.
//  1. Centre tap only, c[15]=0x4000 (0.5), others 0. Feed 1000, then 30 zeros.
//     -> Outputs 1..15 = 0; output 16 = 500; the rest 0. Each out_valid is exactly 19 clk after its sample.
//  2. c[14]=0x2000, c[15]=0x4000 (DC gain 1). 40 samples of 600.
//     -> Once 17 samples are in, filtered = 600; no sample stream exceeds 600.
//  3. Saturation:
//     a) c[15]=0x8000 (-1), input 500 -> filtered = 0.
//     b) c[0..15]=0x4000, steady 1023 -> filtered = 1023.
//  4. Rounding: c[15]=0x4000, inputs 3, then 1 at the same position after re-reset.
//     -> 2 (1.5 rounds up), then 1 (0.5 rounds up).
//  5. Overrun: second sample_valid 5 clk after an accepted one.
//     -> Exactly one out_valid; overrun=1 until clr_overrun; wr_ptr advanced by 1 only.
//     -> Same-cycle set and clr_overrun -> overrun stays 1.
//  6. Reset mid-MAC: drop reset at cycle 10 of a computation.
//     -> busy=0, out_valid never pulses, filtered=0.
//     -> The next sample of 1000 with test-1 ROM produces 0 (history cleared).

Source files
------------

// File: rtl/fir_sequencer_pkg.sv
// rtl/fir_sequencer_pkg.sv - shared sizes, FSM states and modular ring indexing for the FIR sequencer
package fir_sequencer_pkg;

   localparam int NTAPS  = 31;
   localparam int NHALF  = (NTAPS + 1) / 2;
   localparam int DATA_W = 10;
   localparam int COEF_W = 16;
   localparam int ACC_W  = 32;
   localparam int FRAC   = 15;
   localparam int PTR_W  = 5;
   localparam int TAP_W  = 4;
   localparam int PAIR_W = DATA_W + 1;
   localparam int PROD_W = COEF_W + PAIR_W + 1;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      MAC,
      ROUND
   } fir_state_t;

   typedef logic [PTR_W-1:0] ptr_t;

   // (ptr + off) mod 31 for ptr in 0..30 and off in 0..31: a single compare-and-subtract suffices.
   function automatic ptr_t wrap31(input ptr_t ptr, input logic [PTR_W:0] off);
      logic [PTR_W+1:0] sum;
      sum = {2'b00, ptr} + {1'b0, off};
      if (sum >= (PTR_W + 2)'(NTAPS)) begin
         sum = sum - (PTR_W + 2)'(NTAPS);
      end
      return sum[PTR_W-1:0];
   endfunction

endpackage

// File: rtl/fir_sequencer_if.sv
// rtl/fir_sequencer_if.sv - sample input, coefficient ROM and filtered output bundle
interface fir_sequencer_if;
   import fir_sequencer_pkg::*;

   logic                     sample_valid;
   logic [DATA_W-1:0]        sample_in;
   logic [TAP_W-1:0]         coef_addr;
   logic signed [COEF_W-1:0] coef_data;
   logic                     busy;
   logic                     out_valid;
   logic [DATA_W-1:0]        filtered;
   logic                     overrun;
   logic                     clr_overrun;

   modport master (
      output sample_valid, sample_in, coef_data, clr_overrun,
      input  coef_addr, busy, out_valid, filtered, overrun
   );

   modport slave (
      input  sample_valid, sample_in, coef_data, clr_overrun,
      output coef_addr, busy, out_valid, filtered, overrun
   );

endinterface

// File: rtl/fir_sample_ring.sv
// rtl/fir_sample_ring.sv - 31-entry sample history with one write port and two symmetric tap read ports
module fir_sample_ring
   import fir_sequencer_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              we_i,
   input  ptr_t              waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  ptr_t              base_i,
   input  logic [TAP_W-1:0]  tap_i,
   output logic [DATA_W-1:0] near_o,
   output logic [DATA_W-1:0] far_o
);

   logic [DATA_W-1:0] ring_q [NTAPS];
   ptr_t              near_idx;
   ptr_t              far_idx;

   // near = x[n-k] at (base-k) mod 31; far = x[n-30+k] at (base+1+k) mod 31
   always_comb begin
      near_idx = wrap31(base_i, (PTR_W + 1)'(NTAPS) - {2'b00, tap_i});
      far_idx  = wrap31(base_i, (PTR_W + 1)'(1) + {2'b00, tap_i});
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NTAPS; i++) begin
            ring_q[i] <= '0;
         end
      end else if (we_i) begin
         ring_q[waddr_i] <= wdata_i;
      end
   end

   assign near_o = ring_q[near_idx];
   assign far_o  = ring_q[far_idx];

endmodule

// File: rtl/fir_sequencer.sv
// rtl/fir_sequencer.sv - time-multiplexed controller for the 31-tap symmetric FIR
// One multiplier walks the 16 tap pairs; a product register separates multiply from accumulate.
module fir_sequencer
   import fir_sequencer_pkg::*;
(
   input  logic           clk,
   input  logic           reset,
   fir_sequencer_if.slave bus
);

   localparam logic [TAP_W-1:0]        LAST_TAP   = TAP_W'(NHALF - 1);
   localparam logic signed [ACC_W-1:0] ROUND_HALF = ACC_W'(2 ** (FRAC - 1));
   localparam logic signed [ACC_W-1:0] SAT_MAX    = ACC_W'(2 ** DATA_W - 1);

   fir_state_t               state_q, state_d;
   ptr_t                     wr_ptr_q, wr_ptr_d;
   ptr_t                     base_q, base_d;
   logic [TAP_W-1:0]         tap_q, tap_d;
   logic signed [ACC_W-1:0]  acc_q, acc_d;
   logic signed [PROD_W-1:0] prod_q, prod_d;
   logic                     rnd_pend_q, rnd_pend_d;
   logic [DATA_W-1:0]        filtered_q, filtered_d;
   logic                     out_valid_q, out_valid_d;
   logic                     overrun_q, overrun_d;

   logic [TAP_W-1:0]         coef_addr;
   logic [DATA_W-1:0]        near_smp, far_smp;
   logic [PAIR_W-1:0]        pair;
   logic signed [PROD_W-1:0] prod_now;
   logic signed [ACC_W-1:0]  rnd_sum, rnd_shift;
   logic [DATA_W-1:0]        sat_val;
   logic                     accept, drop;

   assign accept = bus.sample_valid && (state_q == IDLE);
   assign drop   = bus.sample_valid && (state_q != IDLE);

   fir_sample_ring u_ring (
      .clk     (clk),
      .reset   (reset),
      .we_i    (accept),
      .waddr_i (wr_ptr_q),
      .wdata_i (bus.sample_in),
      .base_i  (base_q),
      .tap_i   (tap_q),
      .near_o  (near_smp),
      .far_o   (far_smp)
   );

   // The centre tap reads the same ring entry on both ports, so it is taken once.
   always_comb begin
      pair = {1'b0, near_smp};
      if (tap_q != LAST_TAP) begin
         pair = pair + {1'b0, far_smp};
      end
      prod_now  = PROD_W'(bus.coef_data) * PROD_W'($signed({1'b0, pair}));
      rnd_sum   = acc_q + ROUND_HALF;
      rnd_shift = rnd_sum >>> FRAC;
      if (rnd_shift[ACC_W-1]) begin
         sat_val = '0;
      end else if (rnd_shift > SAT_MAX) begin
         sat_val = '1;
      end else begin
         sat_val = rnd_shift[DATA_W-1:0];
      end
   end

   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      base_d      = base_q;
      tap_d       = tap_q;
      acc_d       = acc_q;
      prod_d      = prod_q;
      rnd_pend_d  = 1'b0;
      filtered_d  = filtered_q;
      out_valid_d = 1'b0;
      coef_addr   = '0;
      overrun_d   = drop ? 1'b1 : (bus.clr_overrun ? 1'b0 : overrun_q);

      // Rounding runs the cycle after ROUND, when the last product has landed in acc.
      if (rnd_pend_q) begin
         filtered_d  = sat_val;
         out_valid_d = 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (bus.sample_valid) begin
               base_d   = wr_ptr_q;
               wr_ptr_d = (wr_ptr_q == PTR_W'(NTAPS - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
               state_d  = LOAD;
            end
         end
         LOAD: begin
            acc_d   = '0;
            tap_d   = '0;
            state_d = MAC;
         end
         MAC: begin
            coef_addr = (tap_q == LAST_TAP) ? LAST_TAP : tap_q + TAP_W'(1);
            prod_d    = prod_now;
            if (tap_q != '0) begin
               acc_d = acc_q + ACC_W'(prod_q);
            end
            if (tap_q == LAST_TAP) begin
               state_d = ROUND;
            end else begin
               tap_d = tap_q + TAP_W'(1);
            end
         end
         ROUND: begin
            acc_d      = acc_q + ACC_W'(prod_q);
            rnd_pend_d = 1'b1;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         wr_ptr_q    <= '0;
         base_q      <= '0;
         tap_q       <= '0;
         acc_q       <= '0;
         prod_q      <= '0;
         rnd_pend_q  <= 1'b0;
         filtered_q  <= '0;
         out_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         base_q      <= base_d;
         tap_q       <= tap_d;
         acc_q       <= acc_d;
         prod_q      <= prod_d;
         rnd_pend_q  <= rnd_pend_d;
         filtered_q  <= filtered_d;
         out_valid_q <= out_valid_d;
         overrun_q   <= overrun_d;
      end
   end

   assign bus.coef_addr = coef_addr;
   assign bus.busy      = (state_q != IDLE);
   assign bus.out_valid = out_valid_q;
   assign bus.filtered  = filtered_q;
   assign bus.overrun   = overrun_q;

endmodule
